player_laser: RTL
=================

PLAYER_LASER -- requirements
Module: player_laser

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- color_p, {4'hF,4'hF,4'hF}: laser colour in {R,G,B} format.
- speed_p, 10'd8: pixels moved up per frame.
- length_p, 10'd12: laser height in pixels.
- ship_top_p, 10'd440: top row of the player ship; spawn reference.
- top_border_p, 10'd8: upper playfield limit.
- cooldown_p, 5'd15: frames between laser exit or hit and re-arm.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk_i, in, 1: clock.
- reset_i, in, 1: reset.
- frame_i, in, 1: one-cycle frame tick.
- fire_i, in, 1: shoot request from player.
- gun_pos_i, in, 10: gun x position from player.
- alive_i, in, 1: player alive.
- pause_i, in, 1: level frozen.
- enemy_hit_i, in, 1: collision of laser with an enemy.
- laser_active_o, out, 1: laser on screen.
- laser_x_o, out, 10: laser column.
- laser_top_o, out, 10: laser top row.
- laser_bot_o, out, 10: laser bottom row.
- shot_fired_o, out, 1: one-cycle pulse on launch.
- enemy_kill_o, out, 1: one-cycle pulse on registered hit.
- laser_red_o / laser_green_o / laser_blue_o, out, 4 each: colour.
- state_o, out, 3: present state, for debug.
REQ-003 SHALL use one clock, clk_i, and reset_i, which is asynchronous and active-high.

Function
REQ-004 SHALL implement a one-hot FSM with states IDLE=3'b001, FLYING=3'b010 and COOLDOWN=3'b100; any other encoding SHALL go to IDLE on the next clock.
REQ-005 IDLE: when fire_i & alive_i & ~pause_i, SHALL go to FLYING on the next clock, latching laser_x_o=gun_pos_i and laser_top_o=ship_top_p-length_p.
REQ-006 shot_fired_o SHALL be high for exactly the first FLYING cycle after a launch.
REQ-007 FLYING priority SHALL be: ~alive_i -> IDLE; else enemy_hit_i & ~pause_i -> COOLDOWN with enemy_kill_o pulsed for one cycle; else on frame_i & ~pause_i, if laser_top_o < top_border_p+speed_p -> COOLDOWN, otherwise laser_top_o -= speed_p.
REQ-008 fire_i SHALL be ignored in FLYING and COOLDOWN, with no queuing: one laser at a time.
REQ-009 On entry to COOLDOWN, the cooldown counter SHALL load cooldown_p and decrement on each frame_i & ~pause_i; when the count is 0, the FSM SHALL go to IDLE on the next clock. With cooldown_p=0, COOLDOWN SHALL last exactly one cycle.
REQ-010 ~alive_i in COOLDOWN SHALL force IDLE and clear the counter.
REQ-011 pause_i SHALL freeze laser movement, the cooldown counter and hit detection; state and position SHALL be held.
REQ-012 laser_active_o SHALL be 1 only in FLYING.
REQ-013 laser_bot_o SHALL equal laser_top_o+length_p (combinational, 10-bit, no wrap possible with legal parameters).
REQ-014 laser_x_o and laser_top_o SHALL hold their last values outside FLYING.
REQ-015 Colour outputs SHALL be constant slices of color_p.
REQ-016 All arithmetic SHALL be 10-bit unsigned. Parameters SHALL satisfy ship_top_p > length_p + top_border_p + speed_p.

Reset
REQ-017 reset_i SHALL asynchronously set: state IDLE; laser_x_o=0; laser_top_o=0; cooldown count 0; laser_active_o, shot_fired_o and enemy_kill_o = 0.
REQ-018 reset_i asserted mid-flight SHALL remove the laser immediately, with no kill pulse.

Structure
REQ-019 The state enum and the default geometry constants (border, ship top) SHALL live in a shared package (space_invaders_pkg) used by the player and the laser.
REQ-020 No sub-module is required; the position and cooldown registers SHALL be local to the module.

Verification
REQ-021 gun_pos_i=264, fire_i for 1 cycle -> laser_x_o=264, laser_top_o=428, laser_bot_o=440, shot_fired_o high 1 cycle; after 3 frames laser_top_o=404.
REQ-022 Launch, no hits -> top reaches 20 after 51 frames and 12 after 52; on frame 53, COOLDOWN; IDLE exactly 15 frames later.
REQ-023 enemy_hit_i and frame_i in the same FLYING cycle -> enemy_kill_o=1, position not updated, COOLDOWN.
REQ-024 fire_i held continuously -> exactly one shot_fired_o per FLYING+COOLDOWN cycle; second launch on the first IDLE cycle.
REQ-025 pause_i high for 10 frames mid-flight -> laser_top_o unchanged and enemy_hit_i ignored; motion resumes on release.
REQ-026 alive_i dropped in FLYING, and separately in COOLDOWN -> IDLE next clock, laser_active_o=0; asynchronous reset mid-flight clears all outputs without waiting for a clock edge.

Source files
------------

// File: rtl/space_invaders_pkg.sv
// Shared definitions for the player and laser objects: state encoding and
// default playfield geometry.
package space_invaders_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned COLOR_W = 12;

  localparam logic [COORD_W-1:0] TOP_BORDER = 10'd8;
  localparam logic [COORD_W-1:0] SHIP_TOP   = 10'd440;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b001,
    ST_FLYING   = 3'b010,
    ST_COOLDOWN = 3'b100
  } obj_state_e;

  // Row at which a freshly launched laser places its top edge.
  function automatic logic [COORD_W-1:0] spawn_top(
    input logic [COORD_W-1:0] ship_top,
    input logic [COORD_W-1:0] len
  );
    return ship_top - len;
  endfunction

endpackage

// File: rtl/player_laser.sv
// Player laser: launches from the gun, climbs one step per frame, and re-arms
// after a cooldown once it leaves the playfield or hits an enemy.
module player_laser
  import space_invaders_pkg::*;
#(
  parameter logic [COLOR_W-1:0] color_p      = {4'hF, 4'hF, 4'hF},
  parameter logic [COORD_W-1:0] speed_p      = 10'd8,
  parameter logic [COORD_W-1:0] length_p     = 10'd12,
  parameter logic [COORD_W-1:0] ship_top_p   = SHIP_TOP,
  parameter logic [COORD_W-1:0] top_border_p = TOP_BORDER,
  parameter logic [CNT_W-1:0]   cooldown_p   = 5'd15
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               frame_i,
  input  logic               fire_i,
  input  logic [COORD_W-1:0] gun_pos_i,
  input  logic               alive_i,
  input  logic               pause_i,
  input  logic               enemy_hit_i,
  output logic               laser_active_o,
  output logic [COORD_W-1:0] laser_x_o,
  output logic [COORD_W-1:0] laser_top_o,
  output logic [COORD_W-1:0] laser_bot_o,
  output logic               shot_fired_o,
  output logic               enemy_kill_o,
  output logic [3:0]         laser_red_o,
  output logic [3:0]         laser_green_o,
  output logic [3:0]         laser_blue_o,
  output logic [2:0]         state_o
);

  obj_state_e         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] top_q, top_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_q, active_d;
  logic               shot_q, shot_d;
  logic               kill_q, kill_d;

  logic               run_c;

  // Pause freezes motion, hit detection and the cooldown count.
  assign run_c = ~pause_i;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    shot_d  = 1'b0;
    kill_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire_i && alive_i && run_c) begin
          state_d = ST_FLYING;
          x_d     = gun_pos_i;
          top_d   = spawn_top(ship_top_p, length_p);
          shot_d  = 1'b1;
        end
      end
      ST_FLYING: begin
        if (!alive_i) begin
          state_d = ST_IDLE;
        end else if (enemy_hit_i && run_c) begin
          state_d = ST_COOLDOWN;
          cnt_d   = cooldown_p;
          kill_d  = 1'b1;
        end else if (frame_i && run_c) begin
          // One more step would carry the top edge past the border.
          if (top_q < top_border_p + speed_p) begin
            state_d = ST_COOLDOWN;
            cnt_d   = cooldown_p;
          end else begin
            top_d = top_q - speed_p;
          end
        end
      end
      ST_COOLDOWN: begin
        if (!alive_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (run_c) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else if (frame_i) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d == ST_FLYING);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      top_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      shot_q   <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      top_q    <= top_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shot_q   <= shot_d;
      kill_q   <= kill_d;
    end
  end

  assign laser_active_o = active_q;
  assign laser_x_o      = x_q;
  assign laser_top_o    = top_q;
  assign laser_bot_o    = top_q + length_p;
  assign shot_fired_o   = shot_q;
  assign enemy_kill_o   = kill_q;
  assign state_o        = state_q;

  assign laser_red_o    = color_p[11:8];
  assign laser_green_o  = color_p[7:4];
  assign laser_blue_o   = color_p[3:0];

endmodule
